// File: rtl/avl_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// avl_frame_reader_pkg
// Shared definitions for the Avalon frame reader: default bus widths and the
// controller state enumeration.
// -----------------------------------------------------------------------------
package avl_frame_reader_pkg;

  // Default Avalon word-address and data widths.
  localparam int unsigned AVL_ADDR_W_DEFAULT = 27;
  localparam int unsigned AVL_DATA_W_DEFAULT = 32;

  // Frame fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a start request
    ST_ISSUE = 2'd1,  // issuing single-word read commands
    ST_DRAIN = 2'd2,  // all reads issued, waiting for data and FIFO to empty
    ST_DONE  = 2'd3   // one-cycle completion pulse
  } rd_state_e;

endpackage : avl_frame_reader_pkg

// File: rtl/avl_rd_fifo.sv
// -----------------------------------------------------------------------------
// avl_rd_fifo
// Show-ahead synchronous FIFO: data_o always presents the head word while
// empty_o is low. A push into a full FIFO is accepted only when a pop happens
// in the same cycle; a pop on an empty FIFO is ignored.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (clears pointers and count)
//   push_i   : write data_i into the tail
//   pop_i    : remove the head word
//   data_i   : write data
//   data_o   : head word (valid while empty_o is low)
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module avl_rd_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16   // power of two, >= 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop frees the head slot this cycle, so a push into a full FIFO can
  // still land when paired with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because data_o is only meaningful while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : avl_rd_fifo

// File: rtl/avl_frame_reader.sv
// -----------------------------------------------------------------------------
// avl_frame_reader
// Fetches one frame of FRAME_WORDS consecutive words starting at BASE_ADDR from
// an Avalon-MM memory controller using single-word read bursts, and streams the
// returned words out through a show-ahead FIFO with valid/ready handshaking.
// Reads are throttled so that outstanding reads plus buffered words never
// exceed FIFO_DEPTH, which keeps the FIFO from overflowing in normal use.
//
// Ports
//   iCLK, iRST          : clock and synchronous active-high reset
//   local_init_done     : controller calibration complete (gates iSTART)
//   iSTART              : single-cycle frame fetch request (IDLE only)
//   avl_waitrequest_n   : controller accepts the current command when high
//   avl_address         : word address of the read command
//   avl_read            : read command strobe
//   avl_burstbegin      : mirror of avl_read
//   avl_readdatavalid   : avl_readdata valid this cycle
//   avl_readdata        : returned read data
//   oPIX_DATA/oPIX_VALID: FIFO head word / FIFO non-empty
//   iPIX_READY          : consumer pops the head word when oPIX_VALID is high
//   oBUSY               : state is not IDLE
//   oFRAME_DONE         : one-cycle pulse when the frame has been delivered
//   oERROR              : sticky FIFO overflow flag
// -----------------------------------------------------------------------------
module avl_frame_reader
  import avl_frame_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = AVL_ADDR_W_DEFAULT,
  parameter int unsigned       DATA_W      = AVL_DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter longint unsigned   FRAME_WORDS = 64'd1 << ADDR_W,
  parameter int unsigned       FIFO_DEPTH  = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              local_init_done,
  input  logic              iSTART,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic              avl_readdatavalid,
  input  logic [DATA_W-1:0] avl_readdata,
  output logic [DATA_W-1:0] oPIX_DATA,
  output logic              oPIX_VALID,
  input  logic              iPIX_READY,
  output logic              oBUSY,
  output logic              oFRAME_DONE,
  output logic              oERROR
);

  // Occupancy-sized counters hold 0..FIFO_DEPTH; the issued counter is one
  // bit wider than the address so it can reach 2**ADDR_W.
  localparam int unsigned     CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     ISS_W    = ADDR_W + 1;
  localparam logic [ISS_W-1:0] LAST_IDX = ISS_W'(FRAME_WORDS - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ISS_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [CNT_W:0]    inflight;
  logic              read_en, rd_accept, rd_return, pix_pop;

  // Reads in flight plus words already buffered must fit in the FIFO. This
  // sum never rises while a command is stalled (a return moves one unit from
  // outstanding to the FIFO), so avl_read stays stable under waitrequest.
  assign inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
  assign read_en   = (state_q == ST_ISSUE) && (inflight < (CNT_W + 1)'(FIFO_DEPTH));
  assign rd_accept = read_en & avl_waitrequest_n;

  // Data with nothing outstanding is stray (e.g. late after a reset): drop it.
  assign rd_return = avl_readdatavalid & (outst_q != '0);
  assign pix_pop   = ~fifo_empty & iPIX_READY;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issued_d = issued_q;
    outst_d  = outst_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        addr_d = BASE_ADDR;
        if (iSTART && local_init_done) begin
          state_d  = ST_ISSUE;
          issued_d = '0;
        end
      end
      ST_ISSUE: begin
        if (rd_accept) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + ISS_W'(1);
          if (issued_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outst_q == '0) && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        addr_d  = BASE_ADDR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Simultaneous accept and return cancel out.
    case ({rd_accept, rd_return})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    // A return into a full FIFO with no pop is lost; remember it until reset.
    if (rd_return && fifo_full && !pix_pop) err_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      addr_q   <= BASE_ADDR;
      issued_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  avl_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .push_i  (rd_return),
    .pop_i   (iPIX_READY),
    .data_i  (avl_readdata),
    .data_o  (oPIX_DATA),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign avl_address    = addr_q;
  assign avl_read       = read_en;
  assign avl_burstbegin = read_en;
  assign oPIX_VALID     = ~fifo_empty;
  assign oBUSY          = (state_q != ST_IDLE);
  assign oFRAME_DONE    = (state_q == ST_DONE);
  assign oERROR         = err_q;

endmodule : avl_frame_reader
